// File: rtl/serial_adder_pkg.sv
// Shared encodings and defaults for the bit-serial arithmetic blocks.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the combinational slice reused by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic i,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ i;
  assign c = (a & b) | (a & i) | (b & i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus a registered carry, LSB first.
// state | meaning:  IDLE wait for operands | RUN one bit per clock | DONE hold result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a(a_q[0]),
    .b(b_q[0]),
    .i(carry_q),
    .s(fa_s),
    .c(fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d      = fa_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
